// File: rtl/ctrl_encode_def.sv
// Shared ALU-op, opcode/funct and forwarding-select encodings for the PCPU datapath.
package ctrl_encode_def;

  localparam logic [2:0] ALUOP_NOP = 3'b000;
  localparam logic [2:0] ALUOP_ADD = 3'b001;
  localparam logic [2:0] ALUOP_SUB = 3'b010;
  localparam logic [2:0] ALUOP_AND = 3'b011;
  localparam logic [2:0] ALUOP_OR  = 3'b100;
  localparam logic [2:0] ALUOP_NOR = 3'b101;
  localparam logic [2:0] ALUOP_SLT = 3'b110;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic [1:0] {ImmNone, ImmSext, ImmZext, ImmLui} imm_sel_e;
  typedef enum logic {WregRt, WregRd} wreg_sel_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode/funct decoder: ALU op, immediate kind, destination select, flags.
module alu_ctrl_decode
  import ctrl_encode_def::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctrl_o,
  output imm_sel_e   imm_sel_o,
  output wreg_sel_e  wreg_sel_o,
  output logic       reg_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       branch_o,
  output logic       illegal_o
);

  always_comb begin
    alu_ctrl_o  = ALUOP_NOP;
    imm_sel_o   = ImmNone;
    wreg_sel_o  = WregRt;
    reg_write_o = 1'b0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    branch_o    = 1'b0;
    illegal_o   = 1'b0;
    unique case (op_i)
      OP_RTYPE: begin
        wreg_sel_o  = WregRd;
        reg_write_o = 1'b1;
        unique case (funct_i)
          FUNCT_ADD, FUNCT_ADDU: alu_ctrl_o = ALUOP_ADD;
          FUNCT_SUB, FUNCT_SUBU: alu_ctrl_o = ALUOP_SUB;
          FUNCT_AND:             alu_ctrl_o = ALUOP_AND;
          FUNCT_OR:              alu_ctrl_o = ALUOP_OR;
          FUNCT_NOR:             alu_ctrl_o = ALUOP_NOR;
          FUNCT_SLT:             alu_ctrl_o = ALUOP_SLT;
          default: begin
            reg_write_o = 1'b0;
            illegal_o   = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        alu_ctrl_o = ALUOP_ADD; imm_sel_o = ImmSext; reg_write_o = 1'b1;
      end
      OP_SLTI: begin
        alu_ctrl_o = ALUOP_SLT; imm_sel_o = ImmSext; reg_write_o = 1'b1;
      end
      OP_ANDI: begin
        alu_ctrl_o = ALUOP_AND; imm_sel_o = ImmZext; reg_write_o = 1'b1;
      end
      OP_ORI: begin
        alu_ctrl_o = ALUOP_OR; imm_sel_o = ImmZext; reg_write_o = 1'b1;
      end
      OP_LUI: begin
        alu_ctrl_o = ALUOP_ADD; imm_sel_o = ImmLui; reg_write_o = 1'b1;
      end
      OP_LW: begin
        alu_ctrl_o = ALUOP_ADD; imm_sel_o = ImmSext; reg_write_o = 1'b1; mem_read_o = 1'b1;
      end
      OP_SW: begin
        alu_ctrl_o = ALUOP_ADD; imm_sel_o = ImmSext; mem_write_o = 1'b1;
      end
      OP_BEQ: begin
        alu_ctrl_o = ALUOP_SUB; branch_o = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX stage: decode, operand forwarding/immediate muxing and the ID/EX pipeline register.
module alu_issue_stage
  import ctrl_encode_def::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [31:0]   id_instr,
  input  logic [DW-1:0] id_pc,
  input  logic [DW-1:0] rf_rdata1,
  input  logic [DW-1:0] rf_rdata2,
  input  logic [DW-1:0] exmem_result,
  input  logic [DW-1:0] memwb_result,
  input  logic [1:0]    fwd_a_sel,
  input  logic [1:0]    fwd_b_sel,
  input  logic          stall,
  input  logic          flush,
  output logic          ex_valid,
  output logic [2:0]    ex_alu_ctrl,
  output logic [DW-1:0] ex_data_in1,
  output logic [DW-1:0] ex_data_in2,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_wreg,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_branch,
  output logic [DW-1:0] ex_pc,
  output logic          ex_illegal
);

  typedef struct packed {
    logic          valid;
    logic [2:0]    alu_ctrl;
    logic [DW-1:0] data_in1;
    logic [DW-1:0] data_in2;
    logic [DW-1:0] store_data;
    logic [RW-1:0] wreg;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          branch;
    logic [DW-1:0] pc;
    logic          illegal;
  } ex_reg_t;

  logic [2:0] dec_alu_ctrl;
  imm_sel_e   dec_imm_sel;
  wreg_sel_e  dec_wreg_sel;
  logic       dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_illegal;

  alu_ctrl_decode u_decode (
    .op_i        (id_instr[31:26]),
    .funct_i     (id_instr[5:0]),
    .alu_ctrl_o  (dec_alu_ctrl),
    .imm_sel_o   (dec_imm_sel),
    .wreg_sel_o  (dec_wreg_sel),
    .reg_write_o (dec_reg_write),
    .mem_read_o  (dec_mem_read),
    .mem_write_o (dec_mem_write),
    .branch_o    (dec_branch),
    .illegal_o   (dec_illegal)
  );

  // rs index is consumed by the regfile/hazard unit, not here.
  logic unused_rs;
  assign unused_rs = ^id_instr[25:21];

  logic [DW-1:0] rs_fwd, rt_fwd, imm_ext;
  logic [RW-1:0] wreg;
  ex_reg_t       dec, ex_d, ex_q;

  always_comb begin
    unique case (fwd_a_sel)
      FWD_EXMEM: rs_fwd = exmem_result;
      FWD_MEMWB: rs_fwd = memwb_result;
      default:   rs_fwd = rf_rdata1;
    endcase
    unique case (fwd_b_sel)
      FWD_EXMEM: rt_fwd = exmem_result;
      FWD_MEMWB: rt_fwd = memwb_result;
      default:   rt_fwd = rf_rdata2;
    endcase
    unique case (dec_imm_sel)
      ImmSext: imm_ext = {{(DW-16){id_instr[15]}}, id_instr[15:0]};
      ImmZext: imm_ext = {{(DW-16){1'b0}}, id_instr[15:0]};
      ImmLui:  imm_ext = {{(DW-32){1'b0}}, id_instr[15:0], 16'h0000};
      default: imm_ext = '0;
    endcase
    wreg = (dec_wreg_sel == WregRd) ? RW'(id_instr[15:11]) : RW'(id_instr[20:16]);
  end

  always_comb begin
    dec.valid      = 1'b1;
    dec.alu_ctrl   = dec_alu_ctrl;
    dec.data_in1   = (dec_imm_sel == ImmLui) ? '0 : rs_fwd;
    dec.data_in2   = (dec_imm_sel == ImmNone) ? rt_fwd : imm_ext;
    dec.store_data = rt_fwd;
    dec.wreg       = wreg;
    dec.reg_write  = dec_reg_write && (wreg != '0);
    dec.mem_read   = dec_mem_read;
    dec.mem_write  = dec_mem_write;
    dec.branch     = dec_branch;
    dec.pc         = id_pc;
    dec.illegal    = dec_illegal;
  end

  // Flush beats stall; an invalid decode slot loads the same all-zero bubble.
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (!stall) begin
      ex_d = id_valid ? dec : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_alu_ctrl   = ex_q.alu_ctrl;
  assign ex_data_in1   = ex_q.data_in1;
  assign ex_data_in2   = ex_q.data_in2;
  assign ex_store_data = ex_q.store_data;
  assign ex_wreg       = ex_q.wreg;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_branch     = ex_q.branch;
  assign ex_pc         = ex_q.pc;
  assign ex_illegal    = ex_q.illegal;

endmodule
